// File: rtl/obi_data_arbiter.sv
// Two-master OBI data-port arbiter (scalar core LSU and vector LSU) with an in-order owner FIFO for response routing.
// Optional build macro ARB_VLSU_PRIORITY_EN: fixed VLSU priority on ties instead of round-robin.
module obi_data_arbiter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1),
    localparam int PTR_W          = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  core_req_i,
    output logic                  core_gnt_o,
    input  logic                  core_we_i,
    input  logic [DATA_W/8-1:0]   core_be_i,
    input  logic [ADDR_W-1:0]     core_addr_i,
    input  logic [DATA_W-1:0]     core_wdata_i,
    output logic                  core_rvalid_o,
    output logic [DATA_W-1:0]     core_rdata_o,

    input  logic                  vlsu_req_i,
    output logic                  vlsu_gnt_o,
    input  logic                  vlsu_we_i,
    input  logic [DATA_W/8-1:0]   vlsu_be_i,
    input  logic [ADDR_W-1:0]     vlsu_addr_i,
    input  logic [DATA_W-1:0]     vlsu_wdata_i,
    output logic                  vlsu_rvalid_o,
    output logic [DATA_W-1:0]     vlsu_rdata_o,

    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic                  data_we_o,
    output logic [DATA_W/8-1:0]   data_be_o,
    output logic [ADDR_W-1:0]     data_addr_o,
    output logic [DATA_W-1:0]     data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [DATA_W-1:0]     data_rdata_i,

    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  err_o
);

    typedef enum logic {
        ID_CORE = 1'b0,
        ID_VLSU = 1'b1
    } owner_e;

    owner_e             r_fifo [MAX_OUTSTANDING];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_err;
    logic               r_lock;
    owner_e             r_lock_sel;
    owner_e             r_last_grant;

    logic               w_full;
    logic               w_sel_valid;
    owner_e             w_sel;
    logic               w_push;
    logic               w_pop;
    owner_e             w_head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUTSTANDING - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_full = (r_count == CNT_W'(MAX_OUTSTANDING));

    // A locked selection is an address phase the memory has not yet accepted; it may not be switched.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = ID_CORE;
        if (!w_full) begin
            if (r_lock) begin
                w_sel       = r_lock_sel;
                w_sel_valid = (r_lock_sel == ID_VLSU) ? vlsu_req_i : core_req_i;
            end else if (core_req_i && vlsu_req_i) begin
`ifdef ARB_VLSU_PRIORITY_EN
                w_sel       = ID_VLSU;
`else
                w_sel       = (r_last_grant == ID_VLSU) ? ID_CORE : ID_VLSU;
`endif
                w_sel_valid = 1'b1;
            end else if (core_req_i) begin
                w_sel       = ID_CORE;
                w_sel_valid = 1'b1;
            end else if (vlsu_req_i) begin
                w_sel       = ID_VLSU;
                w_sel_valid = 1'b1;
            end
        end
    end

    always_comb begin
        data_req_o   = w_sel_valid;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (w_sel_valid && (w_sel == ID_CORE)) begin
            data_we_o    = core_we_i;
            data_be_o    = core_be_i;
            data_addr_o  = core_addr_i;
            data_wdata_o = core_wdata_i;
        end else if (w_sel_valid && (w_sel == ID_VLSU)) begin
            data_we_o    = vlsu_we_i;
            data_be_o    = vlsu_be_i;
            data_addr_o  = vlsu_addr_i;
            data_wdata_o = vlsu_wdata_i;
        end
    end

    assign core_gnt_o    = data_gnt_i & w_sel_valid & (w_sel == ID_CORE);
    assign vlsu_gnt_o    = data_gnt_i & w_sel_valid & (w_sel == ID_VLSU);

    assign w_push        = w_sel_valid & data_gnt_i;
    assign w_pop         = data_rvalid_i & (r_count != '0);
    assign w_head        = r_fifo[r_rd_ptr];

    assign core_rvalid_o = w_pop & (w_head == ID_CORE);
    assign vlsu_rvalid_o = w_pop & (w_head == ID_VLSU);
    assign core_rdata_o  = data_rdata_i;
    assign vlsu_rdata_o  = data_rdata_i;

    assign outstanding_o = r_count;
    assign err_o         = r_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                r_fifo[i] <= ID_CORE;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
            r_lock       <= 1'b0;
            r_lock_sel   <= ID_CORE;
            r_last_grant <= ID_VLSU;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= ptr_inc(r_wr_ptr);
                r_last_grant     <= w_sel;
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            // A response with nothing outstanding has no owner; it is dropped and flagged until reset.
            if (data_rvalid_i && (r_count == '0)) begin
                r_err <= 1'b1;
            end
            r_lock <= w_sel_valid & ~data_gnt_i;
            if (w_sel_valid && !data_gnt_i) begin
                r_lock_sel <= w_sel;
            end
        end
    end

endmodule

// File: tb/tb_obi_data_arbiter.sv
// Bench for obi_data_arbiter: directed scenarios followed by random OBI traffic, checked against a queue-based model.
module tb_obi_data_arbiter;

  localparam int MAXO = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int BW   = DW / 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          core_req_i, core_we_i, vlsu_req_i, vlsu_we_i;
  logic [BW-1:0] core_be_i, vlsu_be_i;
  logic [AW-1:0] core_addr_i, vlsu_addr_i;
  logic [DW-1:0] core_wdata_i, vlsu_wdata_i;
  logic          core_gnt_o, vlsu_gnt_o, core_rvalid_o, vlsu_rvalid_o;
  logic [DW-1:0] core_rdata_o, vlsu_rdata_o;
  logic          data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [BW-1:0] data_be_o;
  logic [AW-1:0] data_addr_o;
  logic [DW-1:0] data_wdata_o, data_rdata_i;
  logic [1:0]    outstanding_o;
  logic          err_o;

  always #5 clk = ~clk;

  obi_data_arbiter #(.MAX_OUTSTANDING(MAXO), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o), .core_we_i(core_we_i),
    .core_be_i(core_be_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .core_rvalid_o(core_rvalid_o), .core_rdata_o(core_rdata_o),
    .vlsu_req_i(vlsu_req_i), .vlsu_gnt_o(vlsu_gnt_o), .vlsu_we_i(vlsu_we_i),
    .vlsu_be_i(vlsu_be_i), .vlsu_addr_i(vlsu_addr_i), .vlsu_wdata_i(vlsu_wdata_i),
    .vlsu_rvalid_o(vlsu_rvalid_o), .vlsu_rdata_o(vlsu_rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_we_o(data_we_o),
    .data_be_o(data_be_o), .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: owner queue (0 = core, 1 = vlsu), last winner, pending un-granted owner, sticky error.
  bit m_q[$];
  bit m_last;
  bit m_pend;
  bit m_pend_who;
  bit m_err;

  bit e_valid, e_sel, e_grant, e_pop, e_head, e_stray;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_last     = 1'b1;
    m_pend     = 1'b0;
    m_pend_who = 1'b0;
    m_err      = 1'b0;
  endtask

  task automatic compute();
    e_valid = 1'b0;
    e_sel   = 1'b0;
    if (m_q.size() < MAXO) begin
      if (m_pend) begin
        e_sel   = m_pend_who;
        e_valid = m_pend_who ? vlsu_req_i : core_req_i;
      end else if (core_req_i && vlsu_req_i) begin
`ifdef ARB_VLSU_PRIORITY_EN
        e_sel = 1'b1;
`else
        e_sel = !m_last;
`endif
        e_valid = 1'b1;
      end else if (core_req_i || vlsu_req_i) begin
        e_sel   = vlsu_req_i;
        e_valid = 1'b1;
      end
    end
    e_grant = e_valid && data_gnt_i;
    e_pop   = data_rvalid_i && (m_q.size() > 0);
    e_head  = (m_q.size() > 0) ? m_q[0] : 1'b0;
    e_stray = data_rvalid_i && (m_q.size() == 0);
  endtask

  task automatic sample();
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic [BW-1:0] eb;
    logic          ewe;
    @(negedge clk);
    compute();
    ea = '0; ew = '0; eb = '0; ewe = 1'b0;
    if (e_valid) begin
      ea  = e_sel ? vlsu_addr_i  : core_addr_i;
      ew  = e_sel ? vlsu_wdata_i : core_wdata_i;
      eb  = e_sel ? vlsu_be_i    : core_be_i;
      ewe = e_sel ? vlsu_we_i    : core_we_i;
    end
    chk("data_req", data_req_o, e_valid);
    chk("core_gnt", core_gnt_o, e_grant && !e_sel);
    chk("vlsu_gnt", vlsu_gnt_o, e_grant && e_sel);
    chk("data_addr", data_addr_o, ea);
    chk("data_wdata", data_wdata_o, ew);
    chk("data_be", data_be_o, eb);
    chk("data_we", data_we_o, ewe);
    chk("core_rvalid", core_rvalid_o, e_pop && !e_head);
    chk("vlsu_rvalid", vlsu_rvalid_o, e_pop && e_head);
    chk("core_rdata", core_rdata_o, data_rdata_i);
    chk("vlsu_rdata", vlsu_rdata_o, data_rdata_i);
    chk("outstanding", outstanding_o, m_q.size());
    chk("err", err_o, m_err);
  endtask

  task automatic commit();
    if (e_stray) m_err = 1'b1;
    if (e_pop) void'(m_q.pop_front());
    if (e_grant) begin
      m_q.push_back(e_sel);
      m_last = e_sel;
    end
    m_pend     = e_valid && !data_gnt_i;
    m_pend_who = e_sel;
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    commit();
  endtask

  task automatic set_core(input logic req, input logic [AW-1:0] addr);
    core_req_i   = req;
    core_addr_i  = addr;
    core_we_i    = 1'($urandom);
    core_be_i    = BW'($urandom);
    core_wdata_i = $urandom;
  endtask

  task automatic set_vlsu(input logic req, input logic [AW-1:0] addr);
    vlsu_req_i   = req;
    vlsu_addr_i  = addr;
    vlsu_we_i    = 1'($urandom);
    vlsu_be_i    = BW'($urandom);
    vlsu_wdata_i = $urandom;
  endtask

  task automatic set_mem(input logic gnt, input logic rv, input logic [DW-1:0] rd);
    data_gnt_i    = gnt;
    data_rvalid_i = rv;
    data_rdata_i  = rd;
  endtask

  initial begin
    bit c_hold, v_hold;
    model_reset();
    reset = 1'b1;
    set_core(1'b0, '0);
    set_vlsu(1'b0, '0);
    set_mem(1'b0, 1'b0, '0);
    #1;
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_req", data_req_o, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Tie with zero-wait memory; responses trail grants by one cycle.
    for (int i = 0; i < 6; i++) begin
      set_core(i < 4, 32'h1000 + i);
      set_vlsu(i < 4, 32'h2000 + i);
      set_mem(1'b1, (i >= 1) && (i < 5), $urandom);
      sample();
`ifndef ARB_VLSU_PRIORITY_EN
      if (i < 4) begin
        chk("tie_core_gnt", core_gnt_o, (i % 2) == 0);
        chk("tie_vlsu_gnt", vlsu_gnt_o, (i % 2) == 1);
      end
`endif
      chk("tie_cnt_le2", outstanding_o <= 2, 1);
      commit();
    end

    // Lock: core stalled three cycles while vlsu joins at cycle 1.
    for (int i = 0; i < 5; i++) begin
      set_core(i < 4, 32'h100);
      set_vlsu(i >= 1, 32'h200);
      set_mem(i >= 3, 1'b0, '0);
      sample();
      if (i < 4) begin
        chk("lock_addr", data_addr_o, 32'h100);
        chk("lock_vlsu_gnt", vlsu_gnt_o, 0);
      end
      if (i == 3) chk("lock_core_gnt", core_gnt_o, 1);
      if (i == 4) chk("lock_vlsu_gnt4", vlsu_gnt_o, 1);
      commit();
    end
    set_core(1'b0, '0);
    set_vlsu(1'b0, '0);
    for (int i = 0; i < 2; i++) begin
      set_mem(1'b0, 1'b1, $urandom);
      tick();
    end

    // FIFO full: two grants, then a blocked request until one response frees a slot.
    for (int i = 0; i < 7; i++) begin
      set_core((i == 0) || (i >= 2 && i <= 4), 32'h300 + i);
      set_vlsu(i == 1, 32'h400);
      set_mem(1'b1, i >= 3 && i != 4, (i == 3) ? 32'hDEADBEEF : $urandom);
      sample();
      if (i == 2) begin
        chk("full_req", data_req_o, 0);
        chk("full_core_gnt", core_gnt_o, 0);
        chk("full_vlsu_gnt", vlsu_gnt_o, 0);
      end
      if (i == 3) begin
        chk("full_core_rvalid", core_rvalid_o, 1);
        chk("full_rdata", core_rdata_o, 32'hDEADBEEF);
        chk("full_still_blocked", data_req_o, 0);
      end
      if (i == 4) chk("full_regrant", core_gnt_o, 1);
      commit();
    end
    set_core(1'b0, '0);
    set_vlsu(1'b0, '0);
    while (m_q.size() > 0) begin
      set_mem(1'b0, 1'b1, $urandom);
      tick();
    end

    // Simultaneous push and pop at count 1.
    for (int i = 0; i < 3; i++) begin
      set_core(i == 0, 32'h500);
      set_vlsu(i == 1, 32'h600);
      set_mem(1'b1, i >= 1, $urandom);
      sample();
      if (i == 1) chk("pp_core_rvalid", core_rvalid_o, 1);
      if (i == 2) begin
        chk("pp_count", outstanding_o, 1);
        chk("pp_vlsu_rvalid", vlsu_rvalid_o, 1);
      end
      commit();
    end

    // Stray response, then async reset with two outstanding.
    set_core(1'b0, '0);
    set_vlsu(1'b0, '0);
    set_mem(1'b0, 1'b1, 32'h12345678);
    sample();
    chk("stray_core_rvalid", core_rvalid_o, 0);
    chk("stray_vlsu_rvalid", vlsu_rvalid_o, 0);
    commit();
    for (int i = 0; i < 3; i++) begin
      set_core(i == 0, 32'h700);
      set_vlsu(i == 1, 32'h800);
      set_mem(1'b1, 1'b0, '0);
      sample();
      chk("stray_err_held", err_o, 1);
      commit();
    end
    chk("pre_rst_count", outstanding_o, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_count", outstanding_o, 0);
    chk("async_rst_err", err_o, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    set_mem(1'b0, 1'b1, $urandom);
    tick();
    set_mem(1'b0, 1'b0, '0);
    tick();

`ifdef ARB_VLSU_PRIORITY_EN
    for (int i = 0; i < 6; i++) begin
      set_core(i < 5, 32'h900);
      set_vlsu(i < 4, 32'hA00 + i);
      set_mem(1'b1, i >= 1, $urandom);
      sample();
      if (i < 4) begin
        chk("prio_vlsu_gnt", vlsu_gnt_o, 1);
        chk("prio_core_gnt", core_gnt_o, 0);
      end
      if (i == 4) chk("prio_core_after", core_gnt_o, 1);
      commit();
    end
`endif

    // Random OBI traffic; an un-granted request keeps its payload.
    c_hold = 1'b0;
    v_hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!c_hold) set_core(1'($urandom_range(0, 1)), $urandom);
      if (!v_hold) set_vlsu(1'($urandom_range(0, 1)), $urandom);
      set_mem($urandom_range(0, 3) != 0,
              (m_q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0),
              $urandom);
      sample();
      c_hold = core_req_i && !(e_grant && !e_sel);
      v_hold = vlsu_req_i && !(e_grant && e_sel);
      commit();
    end

    set_core(1'b0, '0);
    set_vlsu(1'b0, '0);
    for (int i = 0; i < 8 && m_q.size() > 0; i++) begin
      set_mem(1'b0, 1'b1, $urandom);
      tick();
    end
    chk("drain_empty", outstanding_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/obi_data_arbiter.md
Name: obi_data_arbiter

Overview:
Shares the single OBI data-memory port between the scalar core LSU and the vector LSU (vector_lsu) in the accelerator top level. Arbitrates address-phase requests and records the owner of each granted transaction in an in-order ID FIFO. Routes each response (rvalid/rdata) back to the requester that issued it. Keeps the OBI rule that an un-granted request is not retracted or switched.

Parameters:
MAX_OUTSTANDING, 2, max granted-but-unanswered transactions (ID FIFO depth, ≥1)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
core_req_i  in  1  core request
core_gnt_o  out  1  core grant
core_we_i  in  1  core write enable
core_be_i  in  DATA_W/8  core byte enables
core_addr_i  in  ADDR_W  core address
core_wdata_i  in  DATA_W  core write data
core_rvalid_o  out  1  core response valid
core_rdata_o  out  DATA_W  core read data
vlsu_req_i, vlsu_gnt_o, vlsu_we_i, vlsu_be_i, vlsu_addr_i, vlsu_wdata_i, vlsu_rvalid_o, vlsu_rdata_o  same widths and directions as the core_* ports  vector LSU requester
data_req_o  out  1  memory request
data_gnt_i  in  1  memory grant
data_we_o  out  1  memory write enable
data_be_o  out  DATA_W/8  memory byte enables
data_addr_o  out  ADDR_W  memory address
data_wdata_o  out  DATA_W  memory write data
data_rvalid_i  in  1  memory response valid
data_rdata_i  in  DATA_W  memory read data
outstanding_o  out  clog2(MAX_OUTSTANDING+1)  current FIFO count
err_o  out  1  sticky: rvalid received with empty FIFO

Behaviour:
- Reset: asynchronous active-high; resets all state regardless of clock. Reset state: FIFO empty, outstanding_o=0, err_o=0, lock=0, last_grant=VLSU (core wins the first tie).
- Request path is combinational. The selected master's req/we/be/addr/wdata drive data_*. With no selection, data_req_o=0 and the other data_* outputs are 0.
- Requests are blocked when count==MAX_OUTSTANDING: data_req_o=0 and both gnts=0, even if data_rvalid_i=1 in the same cycle. The block is available again on the next cycle.
- Selection when not locked: round-robin between the two masters. If only one requests, that one is selected. If both request, the one not in last_grant is selected.
- Lock: if data_req_o=1 and data_gnt_i=0, the selection is registered and held until granted. While locked, the other requester is ignored.
- Grant: x_gnt_o = data_gnt_i AND x selected. In that cycle, push x's ID into the FIFO and update last_grant. Zero-wait grants are supported, giving 1 transaction per cycle.
- Response: when data_rvalid_i=1 and the FIFO is not empty, pop the head ID. Drive rvalid_o for that master only, in the same cycle (combinational). data_rdata_i is sent to both rdata_o ports; only the matching rvalid qualifies it.
- Push and pop in the same cycle: count is unchanged and FIFO order is preserved.
- rvalid with an empty FIFO: dropped, no rvalid_o asserted, err_o set. err_o clears only on reset.
- Reset during an active transaction: outstanding IDs are lost. Any later stray rvalid sets err_o.
- Responses return in order. No reordering and no ID sideband to memory.

Optional Feature:
- Macro: ARB_VLSU_PRIORITY_EN.
- Defined: fixed priority replaces round-robin. VLSU wins every tie; core is served only when VLSU is idle. Lock and FIFO behaviour are unchanged. last_grant is still updated but does not affect selection.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Tie, zero-wait: both req asserted 4 cycles, data_gnt_i=1 → grants alternate core, vlsu, core, vlsu. Responses with rvalid 1 cycle later route in the same order. outstanding_o never exceeds 2.
- Lock: core req, data_gnt_i=0 for 3 cycles, vlsu raises req at cycle 1 → data_addr_o stays at core_addr_i=0x100. vlsu_gnt_o=0 until after core is granted in cycle 3. vlsu is granted in cycle 4.
- FIFO full: MAX_OUTSTANDING=2, two grants with no rvalid → data_req_o=0 and gnts=0 on the third request. After one rvalid (core_rvalid_o=1, rdata=0xDEADBEEF), the next cycle grants again.
- Simultaneous push/pop at count=1: grant vlsu and rvalid for the earlier core transaction in the same cycle → core_rvalid_o=1, count stays 1, and the next rvalid goes to vlsu.
- Stray response: rvalid with empty FIFO → no rvalid_o, err_o=1 and held. Reset asserted mid-transaction with count=2 → outstanding_o=0, err_o=0 immediately, without waiting for a clock edge.
- With ARB_VLSU_PRIORITY_EN: both req asserted continuously with zero-wait memory → vlsu granted every cycle and core_gnt_o=0 until vlsu_req_i drops.
